// File: rtl/cv32_obi_arb_pkg.sv
// Shared types for the OBI instruction/data arbiter: requester IDs and the
// request attribute bundle that is steered onto the shared memory port.
package cv32_obi_arb_pkg;

  localparam int unsigned OBI_ADDR_WIDTH = 32;
  localparam int unsigned OBI_DATA_WIDTH = 32;
  localparam int unsigned OBI_BE_WIDTH   = OBI_DATA_WIDTH / 8;

  typedef enum logic {
    ID_INSTR = 1'b0,
    ID_DATA  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic                      we;
    logic [OBI_BE_WIDTH-1:0]   be;
    logic [OBI_ADDR_WIDTH-1:0] addr;
    logic [OBI_DATA_WIDTH-1:0] wdata;
  } obi_req_t;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == ID_INSTR) ? ID_DATA : ID_INSTR;
  endfunction

endpackage

// File: rtl/cv32_obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module cv32_obi_arb_id_fifo
  import cv32_obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  req_id_e                    push_id,
  input  logic                       pop,
  output req_id_e                    head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_e       mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ID_INSTR;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_id;
        wptr_q        <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32_obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between the core's
// instruction and data interfaces, returning responses in issue order.
module cv32_obi_mem_arbiter
  import cv32_obi_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = OBI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = OBI_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 instr_req_i,
  input  logic [ADDR_WIDTH-1:0]                instr_addr_i,
  output logic                                 instr_gnt_o,
  output logic                                 instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]                instr_rdata_o,
  input  logic                                 data_req_i,
  input  logic                                 data_we_i,
  input  logic [DATA_WIDTH/8-1:0]              data_be_i,
  input  logic [ADDR_WIDTH-1:0]                data_addr_i,
  input  logic [DATA_WIDTH-1:0]                data_wdata_i,
  output logic                                 data_gnt_o,
  output logic                                 data_rvalid_o,
  output logic [DATA_WIDTH-1:0]                data_rdata_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [DATA_WIDTH/8-1:0]              mem_be_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_wdata_o,
  input  logic                                 mem_gnt_i,
  input  logic                                 mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_rvalid_o
);

  // Handshake: a request transfers in the cycle where req and gnt are both
  // high; once req is raised, winner and attributes stay fixed until gnt.
  // A response is one rvalid pulse per transfer, in issue order, with rdata
  // meaningful only while the matching rvalid is high.

  obi_req_t instr_attr;
  obi_req_t data_attr;
  obi_req_t win_attr;
  req_id_e  winner;
  req_id_e  locked_id_q;
  req_id_e  last_q;
  req_id_e  head_id;
  logic     lock_q;
  logic     err_q;
  logic     fifo_full;
  logic     fifo_empty;
  logic     handshake;
  logic     pop;

  always_comb begin
    instr_attr       = '0;
    instr_attr.we    = 1'b0;
    instr_attr.be    = '1;
    instr_attr.addr  = instr_addr_i;
    instr_attr.wdata = '0;
    data_attr        = '0;
    data_attr.we     = data_we_i;
    data_attr.be     = data_be_i;
    data_attr.addr   = data_addr_i;
    data_attr.wdata  = data_wdata_i;
  end

  // A stalled request keeps its winner so the memory sees stable attributes.
  always_comb begin
    winner = ID_INSTR;
    if (lock_q) begin
      winner = locked_id_q;
    end else if (instr_req_i && data_req_i) begin
      winner = other_id(last_q);
    end else if (data_req_i) begin
      winner = ID_DATA;
    end
  end

  assign win_attr    = (winner == ID_DATA) ? data_attr : instr_attr;
  assign mem_we_o    = win_attr.we;
  assign mem_be_o    = win_attr.be;
  assign mem_addr_o  = win_attr.addr;
  assign mem_wdata_o = win_attr.wdata;

  assign mem_req_o   = (instr_req_i | data_req_i) & ~fifo_full;
  assign handshake   = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = handshake & (winner == ID_INSTR);
  assign data_gnt_o  = handshake & (winner == ID_DATA);

  // Responses only ever match entries already recorded in the FIFO.
  assign pop            = mem_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = pop & (head_id == ID_INSTR);
  assign data_rvalid_o  = pop & (head_id == ID_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_rvalid_o   = err_q;

  cv32_obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (handshake),
    .push_id (winner),
    .pop     (pop),
    .head    (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= 1'b0;
      locked_id_q <= ID_INSTR;
      last_q      <= ID_DATA;
      err_q       <= 1'b0;
    end else begin
      if (mem_req_o && !mem_gnt_i) begin
        lock_q      <= 1'b1;
        locked_id_q <= winner;
      end else if (handshake) begin
        lock_q      <= 1'b0;
        last_q      <= winner;
      end
      if (mem_rvalid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32_obi_mem_arbiter.sv
// Directed bench for the OBI arbiter: expected responses are queued at grant
// time and a negedge monitor pops and compares each returned rvalid.
module tb_cv32_obi_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = DW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req;
  logic          data_we;
  logic [3:0]    data_be;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    outstanding_o;
  logic          err_rvalid_o;

  cv32_obi_mem_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .outstanding_o  (outstanding_o),
    .err_rvalid_o   (err_rvalid_o)
  );

  // scoreboard: {port (1=data), rdata}
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req  = 1'b0;
    instr_addr = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = '0;
    data_wdata = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // response monitor
  always @(negedge clk) begin
    if (rst_n && (instr_rvalid_o || data_rvalid_o)) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      a = data_rvalid_o ? {1'b1, data_rdata_o} : {1'b0, instr_rdata_o};
      if (instr_rvalid_o && data_rvalid_o) begin
        total++;
        bad++;
        $display("FAIL rsp_both: instr_rvalid=1 data_rvalid=1 required one-hot");
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %0h required none", a);
      end else begin
        e = exp_q.pop_front();
        check("rsp_port_data", a, e);
      end
    end
  end

  // OBI stability: a stalled request must stay up with the same address
  logic          stall_prev = 1'b0;
  logic [AW-1:0] addr_prev  = '0;
  always @(negedge clk) begin
    if (rst_n && stall_prev) begin
      check("obi_stable_req", mem_req_o, 1'b1);
      check("obi_stable_addr", mem_addr_o, addr_prev);
    end
    stall_prev = rst_n && mem_req_o && !mem_gnt;
    addr_prev  = mem_addr_o;
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // reset state
    @(negedge clk);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_outstanding", outstanding_o, 2'd0);
    check("rst_err", err_rvalid_o, 1'b0);
    check("rst_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
    check("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    tick();
    rst_n = 1'b1;

    // 1: single instruction fetch
    instr_req  = 1'b1;
    instr_addr = 32'h1A00_0080;
    mem_gnt    = 1'b1;
    @(negedge clk);
    check("t1_igrant", instr_gnt_o, 1'b1);
    check("t1_dgrant", data_gnt_o, 1'b0);
    check("t1_addr", mem_addr_o, 32'h1A00_0080);
    check("t1_we_be", {mem_we_o, mem_be_o}, 5'b0_1111);
    exp_q.push_back({1'b0, 32'h0000_0013});
    tick();
    instr_req  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0013;
    @(negedge clk);
    check("t1_drvalid", data_rvalid_o, 1'b0);
    tick();
    mem_rvalid = 1'b0;

    // 2: both requesting every cycle, tie-break alternates from instr
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      instr_req  = (k < 4);
      data_req   = (k < 4);
      instr_addr = 32'h1000 + 32'(k * 4);
      data_addr  = 32'h2000 + 32'(k * 4);
      data_be    = 4'hf;
      mem_gnt    = (k < 4);
      mem_rvalid = (k > 0);
      mem_rdata  = 32'h0000_00A0 + 32'(k) - 32'd1;
      @(negedge clk);
      if (k < 4) begin
        logic exp_i;
        exp_i = ((k % 2) == 0);
        check("t2_igrant", instr_gnt_o, exp_i);
        check("t2_dgrant", data_gnt_o, !exp_i);
        exp_q.push_back({!exp_i, 32'h0000_00A0 + 32'(k)});
      end
      tick();
    end
    mem_rvalid = 1'b0;

    // 3: stalled data write holds attributes, then instr gets the port
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'b0011;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'hCAFE_F00D;
    instr_addr = 32'h1A00_0200;
    for (int k = 0; k < 4; k++) begin
      instr_req = (k > 0);
      mem_gnt   = (k == 3);
      @(negedge clk);
      check("t3_addr", mem_addr_o, 32'h0000_0100);
      check("t3_attr", {mem_we_o, mem_be_o, mem_wdata_o}, {1'b1, 4'b0011, 32'hCAFE_F00D});
      check("t3_dgrant", data_gnt_o, (k == 3));
      check("t3_igrant", instr_gnt_o, 1'b0);
      if (k == 3) exp_q.push_back({1'b1, 32'h5A5A_0001});
      tick();
    end
    data_req   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A_0001;
    @(negedge clk);
    check("t3_igrant_after", instr_gnt_o, 1'b1);
    check("t3_iattr", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
          {1'b0, 4'hf, 32'h1A00_0200, 32'h0});
    exp_q.push_back({1'b0, 32'h5A5A_0002});
    tick();
    instr_req = 1'b0;
    mem_gnt   = 1'b0;
    mem_rdata = 32'h5A5A_0002;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t3_drained", outstanding_o, 2'd0);
    tick();

    // 4: full FIFO blocks requests, even with a same-cycle pop
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h0000_0300;
    mem_gnt    = 1'b1;
    @(negedge clk);
    check("t4_g0", instr_gnt_o, 1'b1);
    exp_q.push_back({1'b0, 32'h0000_0044});
    tick();
    instr_req = 1'b0;
    data_req  = 1'b1;
    data_addr = 32'h0000_0400;
    @(negedge clk);
    check("t4_g1", data_gnt_o, 1'b1);
    exp_q.push_back({1'b1, 32'h0000_0055});
    tick();
    data_req  = 1'b0;
    instr_req = 1'b1;
    @(negedge clk);
    check("t4_full_req", mem_req_o, 1'b0);
    check("t4_full_cnt", outstanding_o, 2'd2);
    check("t4_full_gnt", instr_gnt_o, 1'b0);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0044;
    @(negedge clk);
    check("t4_pop_req", mem_req_o, 1'b0);
    check("t4_pop_gnt", instr_gnt_o, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t4_next_gnt", instr_gnt_o, 1'b1);
    check("t4_next_cnt", outstanding_o, 2'd1);
    exp_q.push_back({1'b0, 32'h0000_0066});
    tick();
    instr_req  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0055;
    tick();
    mem_rdata = 32'h0000_0066;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t4_drained", outstanding_o, 2'd0);
    tick();

    // 5: rvalid with empty FIFO is dropped and flagged
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0BAD;
    @(negedge clk);
    check("t5_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    check("t5_cnt", outstanding_o, 2'd0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t5_err", err_rvalid_o, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    check("t5_err_sticky", err_rvalid_o, 1'b1);
    tick();

    // 6a: asynchronous reset with two outstanding
    instr_req  = 1'b1;
    instr_addr = 32'h0000_0500;
    mem_gnt    = 1'b1;
    tick();
    instr_req = 1'b0;
    data_req  = 1'b1;
    data_addr = 32'h0000_0600;
    data_we   = 1'b0;
    tick();
    data_req = 1'b0;
    mem_gnt  = 1'b0;
    @(negedge clk);
    check("t6_cnt_before", outstanding_o, 2'd2);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_cnt_async", outstanding_o, 2'd0);
    check("t6_err_async", err_rvalid_o, 1'b0);
    check("t6_req_async", mem_req_o, 1'b0);
    tick();
    rst_n = 1'b1;

    // 6b: lock on data is flushed by reset; first tie then goes to instr
    data_req = 1'b1;
    @(negedge clk);
    check("t6_stall_req", {mem_req_o, data_gnt_o}, 2'b10);
    tick();
    rst_n    = 1'b0;
    data_req = 1'b0;
    #1;
    check("t6_cnt_lock", outstanding_o, 2'd0);
    tick();
    rst_n      = 1'b1;
    instr_req  = 1'b1;
    instr_addr = 32'h0000_0700;
    data_req   = 1'b1;
    mem_gnt    = 1'b1;
    @(negedge clk);
    check("t6_tie_igrant", instr_gnt_o, 1'b1);
    check("t6_tie_dgrant", data_gnt_o, 1'b0);
    check("t6_tie_addr", mem_addr_o, 32'h0000_0700);
    tick();
    do_reset();
    tick();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
